// File: rtl/signed_calc_core.sv
// signed_calc_core
//   Signed add/subtract calculator driving a multiplexed decimal 7-segment
//   display. Operands are loaded from the switches by button events; the
//   selected value is converted to BCD with a sequential double-dabble and
//   shown with leading-zero blanking and a minus sign in the top digit.
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   asynchronous reset, active low
//   btn   in   debounced buttons: [0] load A, [1] load B, [2] A+B, [3] A-B
//   sw    in   operand value, two's complement, W bits
//   sel   out  digit enables, active-low one-hot, bit 0 = rightmost digit
//   seg   out  segments, active low, seg[6]=a ... seg[0]=g
//   sign  out  displayed value is negative
//   busy  out  decimal conversion in progress
module signed_calc_core #(
   parameter int W        = 8,
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 50000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        btn,
   input  logic [W-1:0]      sw,
   output logic [DIGITS-1:0] sel,
   output logic [6:0]        seg,
   output logic              sign,
   output logic              busy
);

   localparam int BCDW = 4 * (DIGITS - 1);
   localparam int CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int NW   = $clog2(W + 2);

   localparam logic [NW-1:0]     SHIFT_LAST = NW'(W + 1);
   localparam logic [CW-1:0]     SCAN_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] SEL_RST    = ~(DIGITS'(1));
   localparam logic [6:0]        SEG_BLANK  = 7'b1111111;
   localparam logic [6:0]        SEG_MINUS  = 7'b1111110;

   // Add 3 to every BCD nibble that is 5 or more (double-dabble correction).
   function automatic logic [BCDW-1:0] dd_adjust(input logic [BCDW-1:0] b);
      logic [BCDW-1:0] r;
      r = b;
      for (int k = 0; k < DIGITS - 1; k++) begin
         if (r[4*k +: 4] >= 4'd5) begin
            r[4*k +: 4] = r[4*k +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // BCD digit to active-low segment pattern.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Pattern for one digit position. A digit is a leading zero (blanked)
   // when it and every more significant BCD nibble are zero; digit 0 always
   // shows. The top position carries only the sign.
   function automatic logic [6:0] render(input logic [IW-1:0]   idx,
                                         input logic [BCDW-1:0] bcd,
                                         input logic            neg);
      logic [BCDW-1:0] upper;
      logic [6:0]      s;
      upper = bcd >> {idx, 2'b00};
      if (idx == IDX_LAST) begin
         s = neg ? SEG_MINUS : SEG_BLANK;
      end else if ((idx != IW'(0)) && (upper == '0)) begin
         s = SEG_BLANK;
      end else begin
         s = seg7(upper[3:0]);
      end
      return s;
   endfunction

   logic [3:0]        r_btn;
   logic [W-1:0]      r_a;
   logic [W-1:0]      r_b;
   logic              r_busy;
   logic [NW-1:0]     r_cnt;
   logic [W:0]        r_bin;
   logic [BCDW-1:0]   r_bcd;
   logic              r_psign;
   logic [BCDW-1:0]   r_disp_bcd;
   logic              r_disp_sign;
   logic [CW-1:0]     r_scan_cnt;
   logic [IW-1:0]     r_idx;
   logic [DIGITS-1:0] r_sel;
   logic [6:0]        r_seg;

   logic [3:0]        w_evt;
   logic              w_fire;
   logic              w_load_a;
   logic              w_load_b;
   logic [W:0]        w_v;
   logic [W:0]        w_mag;
   logic [W:0]        w_sa;
   logic [W:0]        w_sb;
   logic [W:0]        w_ssw;
   logic              w_done;
   logic [BCDW+W:0]   w_shift;
   logic [BCDW-1:0]   w_disp_bcd_nxt;
   logic              w_disp_sign_nxt;
   logic              w_scan_wrap;
   logic [IW-1:0]     w_idx_nxt;

   assign w_evt  = btn & ~r_btn;
   assign w_sa   = {r_a[W-1], r_a};
   assign w_sb   = {r_b[W-1], r_b};
   assign w_ssw  = {sw[W-1], sw};
   // |V| fits W+1 bits unsigned, including |-2^W| = 2^W.
   assign w_mag  = w_v[W] ? (~w_v + {{W{1'b0}}, 1'b1}) : w_v;
   assign w_done = r_busy && (r_cnt == SHIFT_LAST);
   assign w_shift = {dd_adjust(r_bcd), r_bin} << 1;

   // Event arbitration: highest-priority new press wins, nothing while busy.
   always_comb begin
      w_fire   = 1'b0;
      w_load_a = 1'b0;
      w_load_b = 1'b0;
      w_v      = '0;
      if (r_busy) begin
         w_fire = 1'b0;
      end else if (w_evt[0]) begin
         w_fire   = 1'b1;
         w_load_a = 1'b1;
         w_v      = w_ssw;
      end else if (w_evt[1]) begin
         w_fire   = 1'b1;
         w_load_b = 1'b1;
         w_v      = w_ssw;
      end else if (w_evt[2]) begin
         w_fire = 1'b1;
         w_v    = w_sa + w_sb;
      end else if (w_evt[3]) begin
         w_fire = 1'b1;
         w_v    = w_sa - w_sb;
      end else begin
         w_fire = 1'b0;
      end
   end

   // Display contents switch to the converted value only on completion.
   always_comb begin
      w_disp_bcd_nxt  = r_disp_bcd;
      w_disp_sign_nxt = r_disp_sign;
      if (w_done) begin
         w_disp_bcd_nxt  = r_bcd;
         w_disp_sign_nxt = r_psign;
      end else begin
         w_disp_bcd_nxt  = r_disp_bcd;
         w_disp_sign_nxt = r_disp_sign;
      end
   end

   // Scan position for the next cycle.
   always_comb begin
      w_scan_wrap = (r_scan_cnt == SCAN_LAST);
      w_idx_nxt   = r_idx;
      if (w_scan_wrap) begin
         w_idx_nxt = (r_idx == IDX_LAST) ? IW'(0) : (r_idx + IW'(1));
      end else begin
         w_idx_nxt = r_idx;
      end
   end

   // Button edge register and operand registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_btn <= 4'b0000;
         r_a   <= '0;
         r_b   <= '0;
      end else begin
         r_btn <= btn;
         if (w_load_a) begin
            r_a <= sw;
         end
         if (w_load_b) begin
            r_b <= sw;
         end
      end
   end

   // Double-dabble converter: load, W+1 shifts, then one completion cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy  <= 1'b0;
         r_cnt   <= '0;
         r_bin   <= '0;
         r_bcd   <= '0;
         r_psign <= 1'b0;
      end else if (w_fire) begin
         r_busy  <= 1'b1;
         r_cnt   <= '0;
         r_bin   <= w_mag;
         r_bcd   <= '0;
         r_psign <= w_v[W];
      end else if (r_busy) begin
         if (r_cnt != SHIFT_LAST) begin
            r_bcd <= w_shift[BCDW+W:W+1];
            r_bin <= w_shift[W:0];
            r_cnt <= r_cnt + NW'(1);
         end else begin
            r_busy <= 1'b0;
         end
      end
   end

   // Display registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_disp_bcd  <= '0;
         r_disp_sign <= 1'b0;
      end else begin
         r_disp_bcd  <= w_disp_bcd_nxt;
         r_disp_sign <= w_disp_sign_nxt;
      end
   end

   // Digit scan; sel and seg are both registered from the next index so
   // they change on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_scan_cnt <= '0;
         r_idx      <= '0;
         r_sel      <= SEL_RST;
         r_seg      <= 7'b0000001;
      end else begin
         r_scan_cnt <= w_scan_wrap ? CW'(0) : (r_scan_cnt + CW'(1));
         r_idx      <= w_idx_nxt;
         r_sel      <= ~(DIGITS'(1) << w_idx_nxt);
         r_seg      <= render(w_idx_nxt, w_disp_bcd_nxt, w_disp_sign_nxt);
      end
   end

   assign sel  = r_sel;
   assign seg  = r_seg;
   assign sign = r_disp_sign;
   assign busy = r_busy;

endmodule

// File: tb/tb_signed_calc_core.sv
// Testbench for signed_calc_core (W=8, DIGITS=4, SCAN_DIV=4).
// An abstract integer model tracks operands, displayed value, busy time and
// scan position; a compare process checks every output on each falling edge,
// and directed scenarios add literal checks of digits and durations.
module tb_signed_calc_core;

   localparam int W        = 8;
   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 4;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b1;
   logic [3:0]        btn   = 4'b0000;
   logic [W-1:0]      sw    = '0;
   logic [DIGITS-1:0] sel;
   logic [6:0]        seg;
   logic              sign;
   logic              busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state
   int         m_a    = 0;
   int         m_b    = 0;
   int         m_disp = 0;
   int         m_pend = 0;
   int         m_left = 0;
   int         m_tick = 0;
   logic [3:0] m_prev = 4'b0000;
   logic [3:0] m_ev;

   always #5 clk = ~clk;

   signed_calc_core #(.W(W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
      .clk  (clk),
      .rst  (rst_n),
      .btn  (btn),
      .sw   (sw),
      .sel  (sel),
      .seg  (seg),
      .sign (sign),
      .busy (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] enc(input int d);
      logic [6:0] s;
      case (d)
         0: s = 7'b0000001;
         1: s = 7'b1001111;
         2: s = 7'b0010010;
         3: s = 7'b0000110;
         4: s = 7'b1001100;
         5: s = 7'b0100100;
         6: s = 7'b0100000;
         7: s = 7'b0001111;
         8: s = 7'b0000000;
         9: s = 7'b0000100;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Expected pattern for a digit position from the displayed integer.
   function automatic logic [6:0] exp_seg(input int idx, input int val);
      int mag;
      int p;
      if (idx == DIGITS - 1) return (val < 0) ? 7'b1111110 : 7'b1111111;
      mag = (val < 0) ? -val : val;
      p = 1;
      for (int k = 0; k < idx; k++) p = p * 10;
      if (idx != 0 && mag < p) return 7'b1111111;
      return enc((mag / p) % 10);
   endfunction

   // Behavioural model, updated on the same edges as the DUT.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_a = 0; m_b = 0; m_disp = 0; m_pend = 0;
            m_left = 0; m_tick = 0; m_prev = 4'b0000;
         end else begin
            m_ev   = btn & ~m_prev;
            m_prev = btn;
            m_tick++;
            if (m_left != 0) begin
               m_left--;
               if (m_left == 0) m_disp = m_pend;
            end else if (m_ev[0]) begin
               m_a = int'($signed(sw)); m_pend = m_a; m_left = W + 2;
            end else if (m_ev[1]) begin
               m_b = int'($signed(sw)); m_pend = m_b; m_left = W + 2;
            end else if (m_ev[2]) begin
               m_pend = m_a + m_b; m_left = W + 2;
            end else if (m_ev[3]) begin
               m_pend = m_a - m_b; m_left = W + 2;
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      int         idx;
      logic [3:0] want_sel;
      forever begin
         @(negedge clk);
         idx      = (m_tick / SCAN_DIV) % DIGITS;
         want_sel = ~(4'b0001 << idx);
         chk("sel",  {28'd0, sel}, {28'd0, want_sel});
         chk("seg",  {25'd0, seg}, {25'd0, exp_seg(idx, m_disp)});
         chk("sign", {31'd0, sign}, (m_disp < 0) ? 32'd1 : 32'd0);
         chk("busy", {31'd0, busy}, (m_left != 0) ? 32'd1 : 32'd0);
      end
   end

   // Advance n cycles; inputs change 2 time units after the rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         step(1);
         n++;
      end
      chk("idle", {31'd0, busy}, 32'd0);
   endtask

   task automatic pulse(input logic [3:0] mask);
      btn = mask;
      step(1);
      btn = 4'b0000;
      wait_idle();
   endtask

   task automatic check_digit(input int idx, input logic [6:0] exp, input string name);
      int         n = 0;
      logic [3:0] want;
      want = ~(4'b0001 << idx);
      while (sel !== want && n < 20) begin
         step(1);
         n++;
      end
      chk({name, "_sel"}, {28'd0, sel}, {28'd0, want});
      chk(name, {25'd0, seg}, {25'd0, exp});
   endtask

   initial begin
      int blen;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_sel",  {28'd0, sel}, 32'h0000000E);
      chk("rst_seg",  {25'd0, seg}, 32'h00000001);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_sign", {31'd0, sign}, 32'd0);
      step(2);
      rst_n = 1'b1;
      step(20);

      // 127 - (-128) = 255, busy length
      sw = 8'h7F; pulse(4'b0001);
      sw = 8'h80; pulse(4'b0010);
      sw = 8'h00;
      btn = 4'b1000;
      step(1);
      btn = 4'b0000;
      blen = 0;
      while (busy && blen < 50) begin
         blen++;
         step(1);
      end
      chk("busy_len", blen, 32'd10);
      chk("model_255", m_disp, 32'd255);
      check_digit(0, 7'b0100100, "d0_255");
      check_digit(1, 7'b0100100, "d1_255");
      check_digit(2, 7'b0010010, "d2_255");
      check_digit(3, 7'b1111111, "d3_255");
      chk("sign_255", {31'd0, sign}, 32'd0);

      // -128 + -128 = -256
      sw = 8'h80; pulse(4'b0001);
      sw = 8'h80; pulse(4'b0010);
      pulse(4'b0100);
      chk("model_m256", m_disp, -256);
      check_digit(3, 7'b1111110, "d3_m256");
      check_digit(2, 7'b0010010, "d2_m256");
      check_digit(1, 7'b0100100, "d1_m256");
      check_digit(0, 7'b0100000, "d0_m256");
      chk("sign_m256", {31'd0, sign}, 32'd1);

      // 5 - 7 = -2
      sw = 8'h05; pulse(4'b0001);
      sw = 8'h07; pulse(4'b0010);
      pulse(4'b1000);
      check_digit(3, 7'b1111110, "d3_m2");
      check_digit(2, 7'b1111111, "d2_m2");
      check_digit(1, 7'b1111111, "d1_m2");
      check_digit(0, 7'b0010010, "d0_m2");
      chk("sign_m2", {31'd0, sign}, 32'd1);

      // Simultaneous load A + add; add edge during busy held past busy
      sw = 8'h03;
      btn = 4'b0101;
      step(1);
      btn = 4'b0000;
      step(2);
      btn = 4'b0100;
      step(15);
      btn = 4'b0000;
      step(3);
      chk("held_busy", {31'd0, busy}, 32'd0);
      chk("model_3", m_disp, 32'd3);
      check_digit(0, 7'b0000110, "d0_3");
      check_digit(1, 7'b1111111, "d1_3");
      chk("sign_3", {31'd0, sign}, 32'd0);

      // Reset in the middle of a conversion
      sw = 8'h10;
      btn = 4'b0001;
      step(1);
      btn = 4'b0000;
      step(4);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_sel",  {28'd0, sel}, 32'h0000000E);
      chk("abort_seg",  {25'd0, seg}, 32'h00000001);
      chk("abort_sign", {31'd0, sign}, 32'd0);
      step(2);
      rst_n = 1'b1;
      step(20);
      chk("post_busy", {31'd0, busy}, 32'd0);
      chk("model_0", m_disp, 32'd0);
      check_digit(0, 7'b0000001, "d0_post");
      check_digit(1, 7'b1111111, "d1_post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
